// File: rtl/cdb_pkg.sv
// cdb_pkg: CDB widths, functional-unit indices and the broadcast packet.
// Shared by cdb_arbiter, rob and the reservation stations.
package cdb_pkg;

    localparam int CDB_NUM_FU = 4;
    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    localparam int FU_ALU  = 0;
    localparam int FU_MULT = 1;
    localparam int FU_DIV  = 2;
    localparam int FU_LSQ  = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  branch;
        logic                  branch_taken;
    } cdb_pkt_t;

    // Index of the set bit of a one-hot vector (0 when none set).
    function automatic int oh_index(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational one-hot picker; search starts at ptr and wraps.
// A zero pointer turns it into a lowest-index-first priority picker.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N  = CDB_NUM_FU,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB between units via one-entry holding slots.
// Define CDB_ARB_RR_EN for round-robin; otherwise the lowest index wins.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Flush,
    input  logic [NUM_FU-1:0]        Fu_valid,
    output logic [NUM_FU-1:0]        Fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  Fu_rd_tag,
    input  logic [NUM_FU*DATA_W-1:0] Fu_data,
    input  logic [NUM_FU-1:0]        Fu_branch,
    input  logic [NUM_FU-1:0]        Fu_branch_taken,
    output logic                     Cdb_valid,
    output logic [TAG_W-1:0]         Cdb_rd_tag,
    output logic [DATA_W-1:0]        Cdb_data,
    output logic                     Cdb_branch,
    output logic                     Cdb_branch_taken,
    output logic [NUM_FU-1:0]        Cdb_grant
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              branch;
        logic              branch_taken;
    } slot_t;

    logic [NUM_FU-1:0] full;
    slot_t             slot  [NUM_FU];
    slot_t             fu_in [NUM_FU];
    logic [NUM_FU-1:0] win;
    logic [NUM_FU-1:0] accept;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     pick_ptr;
    slot_t             win_pkt;

`ifdef CDB_ARB_RR_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] rr_next;

    assign pick_ptr = rr_ptr;
    assign rr_next  = (int'(win_idx) == NUM_FU - 1) ? '0
                                                    : win_idx + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!Flush && (|win)) begin
            rr_ptr <= rr_next;
        end
    end
`else
    assign pick_ptr = '0;
`endif

    // Arbitration sees only registered state, keeping Fu_valid off the ready path.
    rr_pick #(
        .N  (NUM_FU),
        .PW (PW)
    ) u_pick (
        .req   (full),
        .ptr   (pick_ptr),
        .grant (win)
    );

    assign Fu_ready = (reset || Flush) ? '0 : (~full | win);
    assign accept   = Fu_valid & Fu_ready;
    assign win_idx  = PW'(oh_index(32'(win)));
    assign win_pkt  = slot[win_idx];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_in[i].tag          = Fu_rd_tag[i*TAG_W +: TAG_W];
            fu_in[i].data         = Fu_data[i*DATA_W +: DATA_W];
            fu_in[i].branch       = Fu_branch[i];
            fu_in[i].branch_taken = Fu_branch_taken[i];
        end
    end

    // Payload needs no reset: it is only ever read behind a full bit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot[i] <= fu_in[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full             <= '0;
            Cdb_valid        <= 1'b0;
            Cdb_rd_tag       <= '0;
            Cdb_data         <= '0;
            Cdb_branch       <= 1'b0;
            Cdb_branch_taken <= 1'b0;
            Cdb_grant        <= '0;
        end else if (Flush) begin
            full      <= '0;
            Cdb_valid <= 1'b0;
            Cdb_grant <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    full[i] <= 1'b1;
                end else if (win[i]) begin
                    full[i] <= 1'b0;
                end
            end
            Cdb_valid <= |win;
            Cdb_grant <= win;
            if (|win) begin
                Cdb_rd_tag       <= win_pkt.tag;
                Cdb_data         <= win_pkt.data;
                Cdb_branch       <= win_pkt.branch;
                Cdb_branch_taken <= win_pkt.branch_taken;
            end
        end
    end

endmodule
